// File: rtl/dict_builder_pkg.sv
// Shared definitions for the dictionary entry builder: FSM state encoding,
// the "no entry yet" link value, and the latched header record.
package FS1;

    // FSM state encoding (3-bit, legacy-compatible constants)
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LINK   = 3'd1;
    localparam state_t ST_LEN    = 3'd2;
    localparam state_t ST_NAME   = 3'd3;
    localparam state_t ST_OP     = 3'd4;
    localparam state_t ST_COMMIT = 3'd5;

    // Link value of an empty dictionary; truncated to the address width
    localparam logic [31:0] DICT_NULL = '1;

    // Header captured when a new entry is accepted
    typedef struct packed {
        logic [7:0] op;
        logic [6:0] len;
        logic       imm;
    } hdr_t;

endpackage

// File: rtl/dict_builder.sv
// Dictionary entry builder. Lays down one entry per accepted header as
//   link (LBYTES, little-endian) | length byte | name bytes | op byte
// through a byte-wide granted write bus, then links it in by updating
// ctx (latest entry) and here (next free byte).
// Optional feature macro: DICT_IMM_EN (immediate flag in length-byte bit 7).
module dict_builder
    import FS1::*;
#(
    parameter int DICT   = 'h100,
    parameter int ASZ    = 17,
    parameter int LBYTES = 2,
    parameter int NMAX   = 31,
    parameter int DEND   = 'h1ffff
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           w_valid,
    output logic           w_ready,
    input  logic [7:0]     w_op,
    input  logic [6:0]     w_len,
    input  logic           w_imm,
    input  logic           ch_valid,
    output logic           ch_ready,
    input  logic [7:0]     ch_data,
    output logic           mem_we,
    output logic [ASZ-1:0] mem_ai,
    output logic [7:0]     mem_vi,
    input  logic           mem_gnt,
    output logic [ASZ-1:0] ctx,
    output logic [ASZ-1:0] here,
    output logic           busy,
    output logic           done,
    output logic           err
);

    state_t         state_q, state_d;
    logic [ASZ-1:0] ctx_q, ctx_d;
    logic [ASZ-1:0] here_q, here_d;
    logic [ASZ-1:0] entry_q, entry_d;
    logic [ASZ-1:0] addr_q, addr_d;
    logic [6:0]     cnt_q, cnt_d;
    hdr_t           hdr_q, hdr_d;
    logic           err_q, err_d;

    logic [ASZ:0]   hdr_end;
    logic           hdr_bad;
    logic [23:0]    link_word;
    logic [7:0]     len_byte;

    // Entry extent check is done one bit wider than the address so a wrap
    // past the top of the address space is still seen as out of range.
    assign hdr_end = {1'b0, here_q} + (ASZ+1)'(LBYTES) + (ASZ+1)'(w_len)
                   + (ASZ+1)'(1);
    assign hdr_bad = (w_len == 7'd0) || (int'(w_len) > NMAX)
                   || (hdr_end > (ASZ+1)'(DEND));
    assign link_word = 24'(ctx_q);

`ifdef DICT_IMM_EN
    assign len_byte = {hdr_q.imm, hdr_q.len[6:0]};

    if (NMAX > 127) begin : g_nmax_check
        $error("dict_builder: NMAX must not exceed 127 when the immediate flag shares the length byte");
    end
`else
    logic unused_imm;

    assign len_byte   = {1'b0, hdr_q.len};
    assign unused_imm = hdr_q.imm;
`endif

    assign w_ready = (state_q == ST_IDLE) && !start;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_COMMIT);
    assign err     = err_q;
    assign ctx     = ctx_q;
    assign here    = here_q;

    // Write-bus drive: address comes from a register that only advances on
    // a grant, so address/data hold steady while the bus is stalled.
    always_comb begin
        mem_we   = 1'b0;
        mem_ai   = '0;
        mem_vi   = 8'h00;
        ch_ready = 1'b0;
        case (state_q)
            ST_LINK: begin
                mem_we = 1'b1;
                mem_ai = addr_q;
                mem_vi = link_word[{cnt_q[1:0], 3'b000} +: 8];
            end
            ST_LEN: begin
                mem_we = 1'b1;
                mem_ai = addr_q;
                mem_vi = len_byte;
            end
            ST_NAME: begin
                ch_ready = mem_gnt;
                mem_we   = ch_valid;
                mem_ai   = addr_q;
                mem_vi   = ch_data;
            end
            ST_OP: begin
                mem_we = 1'b1;
                mem_ai = addr_q;
                mem_vi = hdr_q.op;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Next-state logic: header intake, byte sequencing and final linking.
    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        here_d  = here_q;
        entry_d = entry_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ctx_d  = DICT_NULL[ASZ-1:0];
                    here_d = ASZ'(DICT);
                end else if (w_valid) begin
                    if (hdr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        hdr_d.op  = w_op;
                        hdr_d.len = w_len;
                        hdr_d.imm = w_imm;
                        entry_d   = here_q;
                        addr_d    = here_q;
                        cnt_d     = 7'd0;
                        state_d   = ST_LINK;
                    end
                end
            end
            ST_LINK: begin
                if (mem_gnt) begin
                    addr_d = addr_q + ASZ'(1);
                    if (cnt_q == 7'(LBYTES - 1)) begin
                        cnt_d   = 7'd0;
                        state_d = ST_LEN;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            ST_LEN: begin
                if (mem_gnt) begin
                    addr_d  = addr_q + ASZ'(1);
                    state_d = ST_NAME;
                end
            end
            ST_NAME: begin
                if (ch_valid && mem_gnt) begin
                    addr_d = addr_q + ASZ'(1);
                    if (cnt_q == hdr_q.len - 7'd1) begin
                        cnt_d   = 7'd0;
                        state_d = ST_OP;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            ST_OP: begin
                if (mem_gnt) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                ctx_d   = entry_q;
                here_d  = addr_q + ASZ'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ctx_q   <= DICT_NULL[ASZ-1:0];
            here_q  <= ASZ'(DICT);
            entry_q <= '0;
            addr_q  <= '0;
            cnt_q   <= 7'd0;
            hdr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
            here_q  <= here_d;
            entry_q <= entry_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/dict_builder.md
DICT_BUILDER -- requirements
Module: dict_builder

Interface
REQ-001 SHALL have parameter DICT, default 'h100, dictionary base address loaded into here on reset/start.
REQ-002 SHALL have parameter ASZ, default 17, address width.
REQ-003 SHALL have parameter LBYTES, default 2, link-field bytes (1..3), little-endian.
REQ-004 SHALL have parameter NMAX, default 31, maximum name length.
REQ-005 SHALL have parameter DEND, default 'h1ffff, last writable dictionary address.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-low reset.
REQ-007 SHALL have ports: start in 1 re-init pulse; w_valid in 1, w_ready out 1, w_op in 8, w_len in 7, w_imm in 1 (header handshake).
REQ-008 SHALL have ports: ch_valid in 1, ch_ready out 1, ch_data in 8 (name byte stream).
REQ-009 SHALL have ports: mem_we out 1, mem_ai out ASZ, mem_vi out 8, mem_gnt in 1 (byte write bus; write completes on mem_we&&mem_gnt).
REQ-010 SHALL have ports: ctx out ASZ latest entry address; here out ASZ next free address; busy out 1; done out 1 pulse; err out 1 pulse.

Function
REQ-011 SHALL implement FSM IDLE, LINK, LEN, NAME, OP, COMMIT.
REQ-012 SHALL drive w_ready=1 only in IDLE with start=0; header accepted on w_valid&&w_ready.
REQ-013 SHALL reject a header with w_len=0, w_len>NMAX, or here+LBYTES+w_len+1>DEND (computed ASZ+1 bits): err=1 one cycle, no writes, stay IDLE.
REQ-014 SHALL on valid header latch op/len/imm, set entry=here, go LINK.
REQ-015 SHALL in LINK write ctx bytes low-first to entry..entry+LBYTES-1, one per granted cycle.
REQ-016 SHALL in LEN write length byte to entry+LBYTES.
REQ-017 SHALL in NAME drive ch_ready=mem_gnt; each ch_valid&&ch_ready writes ch_data to next address; leave after len bytes.
REQ-018 SHALL in OP write w_op to pfa=entry+LBYTES+1+len.
REQ-019 SHALL in COMMIT set ctx=entry, here=pfa+1, done=1 one cycle, return IDLE.
REQ-020 SHALL hold mem_ai/mem_vi/mem_we stable while mem_gnt=0; mem_we=0 in IDLE and COMMIT.
REQ-021 SHALL leave ctx/here unchanged until COMMIT (partial entries never linked).
REQ-022 SHALL take exactly LBYTES+len+3 cycles header-accept to done with mem_gnt=1 and ch_valid=1 continuous.
REQ-023 SHALL assert busy in every state except IDLE.
REQ-024 SHALL in IDLE on start=1 set ctx='1, here=DICT; start wins over w_valid same cycle; start ignored when busy.

Reset
REQ-025 SHALL on rst=0 at posedge clk: state=IDLE, ctx='1, here=DICT, mem_we=0, mem_ai=0, mem_vi=0, done=0, err=0, busy=0, from any state.

Configuration
REQ-026 SHALL with DICT_IMM_EN defined write length byte as {w_imm, w_len[6:0]} and reject NMAX>127 at elaboration.
REQ-027 SHALL without DICT_IMM_EN ignore w_imm and write length byte as {1'b0, w_len}.

Structure
REQ-028 SHALL place FSM state enum, DICT_NULL constant ('1), and header struct (op, len, imm) in shared package FS1.
REQ-029 SHALL be a single module; no sub-module.

Verification
REQ-030 SHALL cover: reset, "dup" op 'h01, gnt=1 -> 'h100..'h106 = FF FF 03 64 75 70 01; ctx='h100, here='h107, done one cycle.
REQ-031 SHALL cover: then "+" op 'h04 -> 'h107..'h10B = 00 01 01 2B 04; ctx='h107, here='h10C.
REQ-032 SHALL cover: mem_gnt toggled every other cycle, ch_valid gaps -> identical memory image, mem_ai/mem_vi stable during stalls.
REQ-033 SHALL cover: w_len=0, then w_len=NMAX+1 -> err pulse each, no mem_we, ctx/here unchanged.
REQ-034 SHALL cover: rst=0 mid-NAME of second word -> ctx='h1ffff, here='h100, state IDLE next cycle.
REQ-035 SHALL cover: DICT_IMM_EN, w_imm=1, len 3 -> length byte 'h83; without macro -> 'h03.
